// File: rtl/serial_in.sv
// -----------------------------------------------------------------------------
// serial_in
//   Serial-to-parallel receiver paired with the 16-bit rotate-left serial
//   transmitter. It shares the transmitter's clk and start. It captures the
//   MSB-first bit stream on d into a WIDTH-bit word and presents that word on
//   dout with a one-cycle valid strobe.
//
//   Optional feature macro: SERIAL_IN_CONT_EN
//     defined   : after a completed frame the receiver stays in RECV and keeps
//                 receiving. Because the transmitter rotates, the same word
//                 recurs every WIDTH cycles.
//     undefined : after a completed frame the receiver returns to IDLE. A new
//                 start is needed for the next frame.
//
// Ports
//   clk    in   1      clock, all state changes on posedge
//   rst_n  in   1      asynchronous active-low reset
//   start  in   1      transmitter load strobe, sampled on posedge clk
//   d      in   1      serial data (transmitter buffer MSB), MSB first
//   dout   out  WIDTH  last completed received word
//   valid  out  1      one-cycle strobe: dout was updated this cycle
//   busy   out  1      high while a frame is being received (state == RECV)
//   abort  out  1      one-cycle strobe: a partial frame was dropped by a new start
//
// Strobe semantics: valid and abort are registered single-cycle pulses with no
// back-pressure. The consumer must take dout in the cycle in which valid is
// high. dout then holds that word until the next completed frame.
// -----------------------------------------------------------------------------
module serial_in #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             d,
    output logic [WIDTH-1:0] dout,
    output logic             valid,
    output logic             busy,
    output logic             abort
);

    localparam int              CW   = $clog2(WIDTH);
    localparam logic [CW-1:0]   LAST = CW'(WIDTH - 1);

    typedef enum logic {
        IDLE = 1'b0,
        RECV = 1'b1
    } state_t;

    state_t             state;
    logic [CW-1:0]      cnt;
    logic [WIDTH-1:0]   shreg;
    logic [WIDTH-1:0]   shreg_next;

    // Word as it stands after taking in the current bit. On the completing
    // edge, this is the full frame.
    assign shreg_next = {shreg[WIDTH-2:0], d};

    // busy is the FSM state itself. This keeps it glitch-free and lets it
    // double as the state observation point.
    assign busy = (state == RECV);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            cnt   <= '0;
            shreg <= '0;
            dout  <= '0;
            valid <= 1'b0;
            abort <= 1'b0;
        end else begin
            valid <= 1'b0;
            abort <= 1'b0;
            if (start) begin
                // The transmitter is loading on this edge, so d is not a
                // frame bit yet. A restart always wins, including on the
                // completing edge. A frame is reported as aborted only if
                // at least one bit of it had been taken in.
                state <= RECV;
                cnt   <= '0;
                if (state == RECV && cnt != '0) begin
                    abort <= 1'b1;
                end
            end else if (state == RECV) begin
                shreg <= shreg_next;
                if (cnt == LAST) begin
                    dout  <= shreg_next;
                    valid <= 1'b1;
                    cnt   <= '0;
`ifdef SERIAL_IN_CONT_EN
                    state <= RECV;
`else
                    state <= IDLE;
`endif
                end else begin
                    cnt <= cnt + 1'b1;
                end
            end
        end
    end

endmodule
